// File: rtl/audio_level_meter_multi.sv
// audio_level_meter_multi: multi-channel PCM level meter with log-scaled bar and peak hold.
// Ports:
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   i_valid/i_ready           sample handshake; i_ready drops while the sample's channel has a section pending
//   i_channel, i_value        channel tag (out-of-range tags are accepted and discarded) and signed sample
//   o_valid/o_ready           indicator word handshake, round-robin across pending channels
//   o_channel, o_array        channel of the word; bits below the bar position set, plus the peak-hold bit
// Optional: define LEVEL_METER_PEAK_DECAY_EN to let a released peak fall one segment per section
// instead of dropping straight to the current position.
module audio_level_meter_multi #(
    parameter int CHANNELS             = 2,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int INDICATOR_WIDTH      = 32,
    parameter int SECTION_SAMPLE_COUNT = 32,
    parameter int PEAK_HOLD_SECTIONS   = 13781,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [CW-1:0]                  i_channel,
    input  logic signed [SAMPLE_WIDTH-1:0] i_value,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [CW-1:0]                  o_channel,
    output logic [INDICATOR_WIDTH-1:0]     o_array
);
    localparam int SW    = SAMPLE_WIDTH;
    localparam int IW    = INDICATOR_WIDTH;
    localparam int NSLOT = 1 << CW;
    localparam int CNTW  = $clog2(SECTION_SAMPLE_COUNT);
    localparam int PW    = $clog2(IW + 1);
    localparam int HW    = (PEAK_HOLD_SECTIONS > 0) ? $clog2(PEAK_HOLD_SECTIONS + 1) : 1;
    localparam int OFF   = 2 * SW - IW;

    logic signed [SW-1:0] min_q [CHANNELS];
    logic signed [SW-1:0] max_q [CHANNELS];
    logic [CNTW-1:0]      cnt_q [CHANNELS];
    logic [SW-1:0]        span_q [CHANNELS];
    logic [PW-1:0]        peak_q [CHANNELS];
    logic [HW-1:0]        hold_q [CHANNELS];
    logic [CHANNELS-1:0]  done_q, pend_q, done_d, clr;
    logic                 o_valid_q;
    logic [CW-1:0]        o_channel_q, rr_q, rr_d, sel;
    logic [IW-1:0]        o_array_q, array_d;
    logic [NSLOT-1:0]     ch_ok, pend_x;
    logic signed [SW-1:0] min_d, max_d;
    logic [SW-1:0]        span_d;
    logic [CNTW-1:0]      cnt_d;
    logic [PW-1:0]        p, peak_d;
    logic [HW-1:0]        hold_d;
    logic                 in_range, acc, first, last, found, load;
    int                   idx;

    // 2*msb + next-bit + 1, shifted down so full scale lands on the top segment.
    function automatic logic [PW-1:0] pos(input logic [SW-1:0] s);
        logic [SW:0] sx;
        int m, b, raw;
        sx = {s, 1'b0};
        m = -1;
        b = 0;
        for (int k = 0; k < SW; k++) begin
            if (s[k]) begin
                m = k;
                b = int'(sx[k]);
            end
        end
        raw = (m < 0) ? 0 : 2 * m + b + 1;
        return (raw <= OFF) ? '0 : PW'(raw - OFF);
    endfunction

    for (genvar g = 0; g < NSLOT; g++) begin : g_ok
        assign ch_ok[g] = (g < CHANNELS);
    end

    assign pend_x    = NSLOT'(pend_q);
    assign in_range  = ch_ok[i_channel];
    assign i_ready   = !in_range || !pend_x[i_channel];
    assign acc       = i_valid && i_ready && in_range;
    assign load      = !o_valid_q || o_ready;
    assign o_valid   = o_valid_q;
    assign o_channel = o_channel_q;
    assign o_array   = o_array_q;

    always_comb begin
        first  = cnt_q[i_channel] == '0;
        last   = cnt_q[i_channel] == CNTW'(SECTION_SAMPLE_COUNT - 1);
        min_d  = (first || i_value < min_q[i_channel]) ? i_value : min_q[i_channel];
        max_d  = (first || i_value > max_q[i_channel]) ? i_value : max_q[i_channel];
        cnt_d  = last ? '0 : cnt_q[i_channel] + 1'b1;
        span_d = max_d - min_d;
        done_d = (acc && last) ? CHANNELS'(1) << i_channel : '0;
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(rr_q) + i;
            idx = (idx >= CHANNELS) ? idx - CHANNELS : idx;
            if (!found && pend_x[CW'(idx)]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
        rr_d = (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
        clr  = (load && found) ? CHANNELS'(1) << sel : '0;
        p    = pos(span_q[sel]);
        if (p >= peak_q[sel]) begin
            peak_d = p;
            hold_d = HW'(PEAK_HOLD_SECTIONS);
        end else if (hold_q[sel] != '0) begin
            peak_d = peak_q[sel];
            hold_d = hold_q[sel] - 1'b1;
        end else begin
`ifdef LEVEL_METER_PEAK_DECAY_EN
            // p < peak here, so one step down never undershoots the current position.
            peak_d = peak_q[sel] - 1'b1;
`else
            peak_d = p;
`endif
            hold_d = '0;
        end
        for (int k = 0; k < IW; k++) array_d[k] = (k < int'(p)) || (k == int'(peak_d) - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                min_q[c]  <= '0;
                max_q[c]  <= '0;
                cnt_q[c]  <= '0;
                span_q[c] <= '0;
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
            done_q      <= '0;
            pend_q      <= '0;
            o_valid_q   <= 1'b0;
            o_channel_q <= '0;
            o_array_q   <= '0;
            rr_q        <= '0;
        end else begin
            if (acc) begin
                min_q[i_channel] <= min_d;
                max_q[i_channel] <= max_d;
                cnt_q[i_channel] <= cnt_d;
                if (last) span_q[i_channel] <= span_d;
            end
            done_q <= done_d;
            // i_ready is low while pending, so set and clear never target the same channel.
            pend_q <= (pend_q | done_q) & ~clr;
            if (load) begin
                o_valid_q <= found;
                if (found) begin
                    o_channel_q  <= sel;
                    o_array_q    <= array_d;
                    peak_q[sel]  <= peak_d;
                    hold_q[sel]  <= hold_d;
                    rr_q         <= rr_d;
                end
            end
        end
    end
endmodule
